// File: rtl/control_fsm.sv
// Multi-cycle control FSM for a small ARMv8-subset datapath.
// The FSM fetches an instruction and decodes it. It then sequences execute, memory and
// write-back, and emits one-cycle strobes for the IR, PC and register file.
//
// Ports:
//   iClk       - clock; all state updates on the rising edge
//   iRst_n     - synchronous active-low reset
//   iOpcode    - instruction bits [31:21]; valid from DECODE until the FSM returns to FETCH
//   iMemReady  - memory handshake; a request completes in any cycle this is high
//   iZero      - ALU zero flag, used in BRANCH
//   oALUOp     - 00 add, 01 pass/compare, 10 use funct field
//   oALUSrc    - 1 selects the immediate as ALU operand B
//   oReg2Loc   - 1 selects the Rt field for register read port 2
//   oRegWrite  - register file write strobe
//   oMemRead   - memory read request
//   oMemWrite  - memory write request
//   oMemtoReg  - 1 selects memory data for write-back
//   oIRWrite   - instruction register load strobe
//   oPCWrite   - PC <= PC + 4 strobe
//   oPCBranch  - PC <= branch target strobe
//   oIllegal   - one-cycle pulse on an unrecognised opcode
//   oState     - current state code, for debug
module control_fsm (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [10:0] iOpcode,
  input  logic        iMemReady,
  input  logic        iZero,
  output logic [1:0]  oALUOp,
  output logic        oALUSrc,
  output logic        oReg2Loc,
  output logic        oRegWrite,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oMemtoReg,
  output logic        oIRWrite,
  output logic        oPCWrite,
  output logic        oPCBranch,
  output logic        oIllegal,
  output logic [3:0]  oState
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StAddr    = 4'd3,
    StMemRd   = 4'd4,
    StMemWr   = 4'd5,
    StWbR     = 4'd6,
    StWbMem   = 4'd7,
    StBranch  = 4'd8,
    StIllegal = 4'd9
  } state_e;

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;

  state_e state_q, state_d;

  logic is_rtype, is_ldur, is_stur, is_cbz, is_b;

  assign is_rtype = (iOpcode == OpAdd) || (iOpcode == OpSub) ||
                    (iOpcode == OpAnd) || (iOpcode == OpOrr);
  assign is_ldur  = (iOpcode == OpLdur);
  assign is_stur  = (iOpcode == OpStur);
  assign is_cbz   = (iOpcode[10:3] == 8'b10110100);
  assign is_b     = (iOpcode[10:5] == 6'b000101);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = StFetch;
    oALUOp    = 2'b00;
    oALUSrc   = 1'b0;
    oReg2Loc  = 1'b0;
    oRegWrite = 1'b0;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    oMemtoReg = 1'b0;
    oIRWrite  = 1'b0;
    oPCWrite  = 1'b0;
    oPCBranch = 1'b0;
    oIllegal  = 1'b0;

    case (state_q)
      StFetch: begin
        oMemRead = 1'b1;
        if (iMemReady) begin
          oIRWrite = 1'b1;
          oPCWrite = 1'b1;
          state_d  = StDecode;
        end else begin
          state_d  = StFetch;
        end
      end
      StDecode: begin
        if (is_rtype) begin
          state_d = StExecR;
        end else if (is_ldur || is_stur) begin
          state_d = StAddr;
        end else if (is_cbz) begin
          state_d = StBranch;
        end else if (is_b) begin
          // Unconditional branch completes here; target is already computed.
          oPCBranch = 1'b1;
          state_d   = StFetch;
        end else begin
          state_d = StIllegal;
        end
      end
      StExecR: begin
        oALUOp  = 2'b10;
        state_d = StWbR;
      end
      StWbR: begin
        oALUOp    = 2'b10;
        oRegWrite = 1'b1;
        state_d   = StFetch;
      end
      StAddr: begin
        oALUSrc  = 1'b1;
        oReg2Loc = 1'b1;
        if (is_ldur) begin
          state_d = StMemRd;
        end else if (is_stur) begin
          state_d = StMemWr;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRd: begin
        oALUSrc  = 1'b1;
        oMemRead = 1'b1;
        state_d  = iMemReady ? StWbMem : StMemRd;
      end
      StMemWr: begin
        oALUSrc   = 1'b1;
        oReg2Loc  = 1'b1;
        oMemWrite = 1'b1;
        state_d   = iMemReady ? StFetch : StMemWr;
      end
      StWbMem: begin
        oMemtoReg = 1'b1;
        oRegWrite = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        oALUOp    = 2'b01;
        oReg2Loc  = 1'b1;
        oPCBranch = iZero;
        state_d   = StFetch;
      end
      StIllegal: begin
        oIllegal = 1'b1;
        state_d  = StFetch;
      end
      // Unused codes recover to FETCH with all outputs low.
      default: state_d = StFetch;
    endcase
  end

  assign oState = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized self-checking bench for control_fsm.
// Each instruction is expanded into a per-cycle script from the per-state output table.
// Every script entry holds the inputs to drive and the full expected output vector.
module tb_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [10:0] opcode;
  logic        mem_ready;
  logic        zero;
  logic [1:0]  alu_op;
  logic        alu_src, reg2loc, reg_write, mem_read, mem_write, mem_to_reg;
  logic        ir_write, pc_write, pc_branch, illegal;
  logic [3:0]  state;

  control_fsm dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iOpcode   (opcode),
    .iMemReady (mem_ready),
    .iZero     (zero),
    .oALUOp    (alu_op),
    .oALUSrc   (alu_src),
    .oReg2Loc  (reg2loc),
    .oRegWrite (reg_write),
    .oMemRead  (mem_read),
    .oMemWrite (mem_write),
    .oMemtoReg (mem_to_reg),
    .oIRWrite  (ir_write),
    .oPCWrite  (pc_write),
    .oPCBranch (pc_branch),
    .oIllegal  (illegal),
    .oState    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packed as {state, aluop, alusrc, reg2loc, regwrite, memread, memwrite, memtoreg,
  //            irwrite, pcwrite, pcbranch, illegal}.
  function automatic logic [15:0] mk(input int st, input int alu, input int src, input int r2l,
                                     input int rw, input int mr, input int mw, input int m2r,
                                     input int ir, input int pcw, input int pcb, input int ill);
    return {4'(st), 2'(alu), 1'(src), 1'(r2l), 1'(rw), 1'(mr), 1'(mw), 1'(m2r), 1'(ir),
            1'(pcw), 1'(pcb), 1'(ill)};
  endfunction

  // Instruction classes: 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 illegal.
  function automatic int classify(input logic [10:0] op);
    logic [7:0] top8;
    logic [5:0] top6;
    top8 = op[10:3];
    top6 = op[10:5];
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return 0;
    if (op == 11'b11111000010) return 1;
    if (op == 11'b11111000000) return 2;
    if (top8 == 8'b10110100) return 3;
    if (top6 == 6'b000101) return 4;
    return 5;
  endfunction

  typedef struct {
    logic [10:0] op;
    logic        rdy;
    logic        z;
    logic [15:0] exp;
  } cyc_t;

  cyc_t script[$];
  int   instr_no = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [10:0] op, input logic rdy, input logic z,
                      input logic [15:0] exp);
    cyc_t c;
    c.op = op; c.rdy = rdy; c.z = z; c.exp = exp;
    script.push_back(c);
  endtask

  // Build and run one instruction. fw/mw are memory wait cycles in fetch/memory access,
  // zmode 0/1 forces iZero, 2 randomizes it. abort_at >= 0 pulls reset in that cycle.
  task automatic run_instr(input logic [10:0] op, input int fw, input int mw, input int zmode,
                           input int abort_at);
    int   cls;
    logic z;
    logic [15:0] got;
    cls = classify(op);
    script.delete();
    for (int i = 0; i < fw; i++) push(11'($urandom), 1'b0, rbit(), mk(0,0,0,0,0,1,0,0,0,0,0,0));
    push(11'($urandom), 1'b1, rbit(), mk(0,0,0,0,0,1,0,0,1,1,0,0));
    push(op, rbit(), rbit(), mk(1,0,0,0,0,0,0,0,0,0,(cls == 4) ? 1 : 0,0));
    case (cls)
      0: begin
        push(op, rbit(), rbit(), mk(2,2,0,0,0,0,0,0,0,0,0,0));
        push(op, rbit(), rbit(), mk(6,2,0,0,1,0,0,0,0,0,0,0));
      end
      1: begin
        push(op, rbit(), rbit(), mk(3,0,1,1,0,0,0,0,0,0,0,0));
        for (int i = 0; i < mw; i++) push(op, 1'b0, rbit(), mk(4,0,1,0,0,1,0,0,0,0,0,0));
        push(op, 1'b1, rbit(), mk(4,0,1,0,0,1,0,0,0,0,0,0));
        push(op, rbit(), rbit(), mk(7,0,0,0,1,0,0,1,0,0,0,0));
      end
      2: begin
        push(op, rbit(), rbit(), mk(3,0,1,1,0,0,0,0,0,0,0,0));
        for (int i = 0; i < mw; i++) push(op, 1'b0, rbit(), mk(5,0,1,1,0,0,1,0,0,0,0,0));
        push(op, 1'b1, rbit(), mk(5,0,1,1,0,0,1,0,0,0,0,0));
      end
      3: begin
        z = (zmode == 2) ? rbit() : 1'(zmode);
        push(op, rbit(), z, mk(8,1,0,1,0,0,0,0,0,0,int'(z),0));
      end
      4: ;
      default: push(op, rbit(), rbit(), mk(9,0,0,0,0,0,0,0,0,0,0,1));
    endcase
    instr_no++;
    for (int i = 0; i < script.size(); i++) begin
      @(negedge clk);
      opcode    = script[i].op;
      mem_ready = script[i].rdy;
      zero      = script[i].z;
      rst_n     = (i == abort_at) ? 1'b0 : 1'b1;
      #1;
      got = {state, alu_op, alu_src, reg2loc, reg_write, mem_read, mem_write, mem_to_reg,
             ir_write, pc_write, pc_branch, illegal};
      check_eq($sformatf("instr%0d op=%b cyc%0d", instr_no, op, i), got, script[i].exp);
      if (i == abort_at) break;
    end
  endtask

  logic [10:0] pool [0:8];

  initial begin
    logic [10:0] op;
    int          pick, abort;
    pool[0] = 11'b10001011000; pool[1] = 11'b11001011000; pool[2] = 11'b10001010000;
    pool[3] = 11'b10101010000; pool[4] = 11'b11111000010; pool[5] = 11'b11111000000;
    pool[6] = 11'b10110100000; pool[7] = 11'b00010100000; pool[8] = 11'b11111111111;

    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_state", {state, alu_op, alu_src, reg2loc, reg_write, mem_read, mem_write,
             mem_to_reg, ir_write, pc_write, pc_branch, illegal}, mk(0,0,0,0,0,1,0,0,0,0,0,0));

    // Directed cases.
    run_instr(11'b10001011000, 0, 0, 0, -1);   // ADD
    run_instr(11'b11111000010, 0, 2, 0, -1);   // LDUR with two wait cycles
    run_instr(11'b10110100101, 0, 0, 1, -1);   // CBZ taken
    run_instr(11'b10110100101, 0, 0, 0, -1);   // CBZ not taken
    run_instr(11'b00010111111, 0, 0, 0, -1);   // B
    run_instr(11'b11111111111, 0, 0, 0, -1);   // illegal
    run_instr(11'b11111000000, 0, 3, 0, 3);    // STUR reset while stalled in MEM_WR
    run_instr(11'b10001011000, 1, 0, 0, -1);   // first cycle must be a clean FETCH
    run_instr(11'b11111000010, 0, 2, 0, 4);    // LDUR reset while stalled in MEM_RD
    run_instr(11'b10001011001, 0, 0, 0, -1);   // near-miss of ADD is illegal

    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 10);
      if (pick <= 8) op = pool[pick];
      else op = 11'($urandom);
      if (pick == 6) op[2:0] = 3'($urandom);
      if (pick == 7) op[4:0] = 5'($urandom);
      abort = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                int'($urandom_range(0, 3)), 2, abort);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
